// File: rtl/pc_sequencer.sv
// Program-counter stage feeding the fetch stage: +4 stepping, stall, branch/jump
// redirects with a two-cycle squash window, and halt/resume.
//
// state  | meaning
// BOOT   | first cycle after reset; inputs ignored, fetch starts next cycle
// RUN    | normal sequential fetch
// FLUSH  | redirect taken; Squash high until two unstalled cycles have passed
// HALTED | fetch suspended until Resume
module pc_sequencer #(
  parameter int                DEPTHI       = 16,
  parameter logic [DEPTHI-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [15:0]       BranchOffset,
  input  logic              Jump,
  input  logic [25:0]       JumpTarget,
  input  logic              Halt,
  input  logic              Resume,
  output logic [DEPTHI-1:0] Counter,
  output logic [DEPTHI-1:0] CounterPlus4,
  output logic              FetchValid,
  output logic              Squash,
  output logic              Halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DEPTHI-1:0] counter_q, counter_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              squash_q, squash_d;
  logic              halted_q, halted_d;
  logic              flush_cnt_q, flush_cnt_d;

  logic [DEPTHI-1:0] counter_plus4;
  logic [DEPTHI-1:0] jump_addr;
  logic [DEPTHI-1:0] branch_addr;

  assign counter_plus4 = counter_q + DEPTHI'(4);
  // Both targets are built wide then truncated so any DEPTHI wraps modulo 2^DEPTHI.
  assign jump_addr     = DEPTHI'({JumpTarget, 2'b00});
  assign branch_addr   = counter_plus4 +
                         DEPTHI'({{DEPTHI{BranchOffset[15]}}, BranchOffset, 2'b00});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= BOOT;
      counter_q     <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      squash_q      <= 1'b0;
      halted_q      <= 1'b0;
      flush_cnt_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      fetch_valid_q <= fetch_valid_d;
      squash_q      <= squash_d;
      halted_q      <= halted_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    fetch_valid_d = fetch_valid_q;
    squash_d      = squash_q;
    halted_d      = halted_q;
    flush_cnt_d   = flush_cnt_q;
    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN, FLUSH: begin
        if (Halt) begin
          state_d       = HALTED;
          fetch_valid_d = 1'b0;
          squash_d      = 1'b0;
          halted_d      = 1'b1;
          flush_cnt_d   = 1'b0;
        end else if (Jump || BranchTaken) begin
          counter_d     = Jump ? jump_addr : branch_addr;
          state_d       = FLUSH;
          flush_cnt_d   = 1'b1;
          squash_d      = 1'b1;
          fetch_valid_d = 1'b1;
        end else if (!Stall) begin
          counter_d     = counter_plus4;
          fetch_valid_d = 1'b1;
          if (state_q == FLUSH) begin
            if (flush_cnt_q) begin
              flush_cnt_d = 1'b0;
              squash_d    = 1'b1;
            end else begin
              state_d  = RUN;
              squash_d = 1'b0;
            end
          end
        end
      end
      HALTED: begin
        fetch_valid_d = 1'b0;
        squash_d      = 1'b0;
        if (Resume && !Halt) begin
          state_d       = RUN;
          counter_d     = counter_plus4;
          fetch_valid_d = 1'b1;
          halted_d      = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign Counter      = counter_q;
  assign CounterPlus4 = counter_plus4;
  assign FetchValid   = fetch_valid_q;
  assign Squash       = squash_q;
  assign Halted       = halted_q;

endmodule
